// File: rtl/seg_pkg.sv
// +-----------------------------------------------------------------------+
// | Package : seg_pkg                                                     |
// | Shared types and constants for the 5-stage segmented core.            |
// | Rev     : 1.0  initial release                                        |
// +-----------------------------------------------------------------------+
`default_nettype none

package seg_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        MC_WAIT  = 2'd2
    } hz_state_t;

    localparam logic [4:0]  REG_ZERO   = 5'd0;
    localparam int          MC_TIMER_W = 8;

    // Bubble encodings loaded by the pipeline registers on a flush
    localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;
    localparam logic [4:0]  NOP_RD     = REG_ZERO;

endpackage

`default_nettype wire

// File: rtl/hazard_perf_counters.sv
// +-----------------------------------------------------------------------+
// | Module : hazard_perf_counters                                         |
// | Three saturating event counters driven by single-cycle strobes.       |
// | Rev    : 1.0  initial release                                         |
// +-----------------------------------------------------------------------+
`default_nettype none

module hazard_perf_counters #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall_inc,
    input  logic             flush_inc,
    input  logic             mc_inc,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] mc_cnt
);

    logic [CNT_W-1:0] r_cnt [3];
    logic [2:0]       w_inc;

    assign w_inc = {mc_inc, flush_inc, stall_inc};

    for (genvar i = 0; i < 3; i++) begin : g_cnt
        always_ff @(posedge clk) begin
            if (rst)
                r_cnt[i] <= '0;
            else if (w_inc[i] && (r_cnt[i] != '1))
                r_cnt[i] <= r_cnt[i] + 1'b1;
        end
    end

    assign stall_cnt = r_cnt[0];
    assign flush_cnt = r_cnt[1];
    assign mc_cnt    = r_cnt[2];

endmodule

`default_nettype wire

// File: rtl/hazard_control_unit.sv
// +-----------------------------------------------------------------------+
// | Module : hazard_control_unit                                          |
// | Stall/flush sequencer: load-use, taken branch, multi-cycle EX ops.    |
// | Option : HAZARD_PERF_EN builds the saturating performance counters.   |
// | Rev    : 1.0  initial release                                         |
// +-----------------------------------------------------------------------+
`default_nettype none

module hazard_control_unit
    import seg_pkg::*;
#(
    parameter int MC_TIMEOUT = 64,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_ruwr,
    input  logic             ex_dmrd,
    input  logic             ex_br_taken,
    input  logic             ex_mc_start,
    input  logic             mc_done,
    output logic             pc_wr,
    output logic             if_id_wr,
    output logic             if_id_flush,
    output logic             id_ex_wr,
    output logic             id_ex_flush,
    output logic             ex_me_flush,
    output logic             mc_timeout,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] mc_cnt
);

    localparam logic [MC_TIMER_W-1:0] c_mc_limit = MC_TIMER_W'(MC_TIMEOUT);

    hz_state_t             r_state;
    hz_state_t             w_state_nxt;
    logic [MC_TIMER_W-1:0] r_timer;
    logic [MC_TIMER_W-1:0] w_timer_nxt;
    logic                  r_mc_timeout;
    logic                  w_timeout_set;
    logic                  w_lu_hit;

    assign w_lu_hit = ex_dmrd && ex_ruwr && (ex_rd != REG_ZERO) &&
                      ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                       (id_use_rs2 && (id_rs2 == ex_rd)));

    always_comb begin
        pc_wr         = 1'b1;
        if_id_wr      = 1'b1;
        id_ex_wr      = 1'b1;
        if_id_flush   = 1'b0;
        id_ex_flush   = 1'b0;
        ex_me_flush   = 1'b0;
        w_state_nxt   = RUN;
        w_timer_nxt   = '0;
        w_timeout_set = 1'b0;
        if (rst) begin
            pc_wr       = 1'b0;
            if_id_wr    = 1'b0;
            id_ex_wr    = 1'b0;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            ex_me_flush = 1'b1;
        end else begin
            case (r_state)
                RUN: begin
                    if (ex_mc_start) begin
                        pc_wr       = 1'b0;
                        if_id_wr    = 1'b0;
                        id_ex_wr    = 1'b0;
                        ex_me_flush = 1'b1;
                        w_state_nxt = MC_WAIT;
                        w_timer_nxt = MC_TIMER_W'(1);
                    end else if (ex_br_taken) begin
                        // ID instruction is squashed, so its load-use hit is moot
                        if_id_flush = 1'b1;
                        id_ex_flush = 1'b1;
                    end else if (w_lu_hit) begin
                        pc_wr       = 1'b0;
                        if_id_wr    = 1'b0;
                        id_ex_flush = 1'b1;
                        w_state_nxt = LU_STALL;
                    end
                end
                LU_STALL: w_state_nxt = RUN;
                MC_WAIT: begin
                    if (mc_done) begin
                        w_state_nxt = RUN;
                    end else if (r_timer >= c_mc_limit) begin
                        w_timeout_set = 1'b1;
                        w_state_nxt   = RUN;
                    end else begin
                        pc_wr       = 1'b0;
                        if_id_wr    = 1'b0;
                        id_ex_wr    = 1'b0;
                        ex_me_flush = 1'b1;
                        w_state_nxt = MC_WAIT;
                        w_timer_nxt = r_timer + 1'b1;
                    end
                end
                default: w_state_nxt = RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= RUN;
            r_timer      <= '0;
            r_mc_timeout <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_timer <= w_timer_nxt;
            if (w_timeout_set)
                r_mc_timeout <= 1'b1;
        end
    end

    assign mc_timeout = r_mc_timeout;
    assign state_o    = r_state;

`ifdef HAZARD_PERF_EN
    logic w_stall_inc;
    logic w_flush_inc;
    logic w_mc_inc;

    assign w_stall_inc = !rst && (r_state == RUN) && !ex_mc_start && !ex_br_taken && w_lu_hit;
    assign w_flush_inc = !rst && (r_state == RUN) && !ex_mc_start && ex_br_taken;
    assign w_mc_inc    = !rst && (r_state == MC_WAIT);

    hazard_perf_counters #(
        .CNT_W (CNT_W)
    ) u_perf (
        .clk       (clk),
        .rst       (rst),
        .stall_inc (w_stall_inc),
        .flush_inc (w_flush_inc),
        .mc_inc    (w_mc_inc),
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt),
        .mc_cnt    (mc_cnt)
    );
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
    assign mc_cnt    = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_hazard_control_unit.sv
// +-----------------------------------------------------------------------+
// | Module : tb_hazard_control_unit                                       |
// | Scoreboarded bench for hazard_control_unit (MC_TIMEOUT = 4).          |
// | Rev    : 1.0  initial release                                         |
// +-----------------------------------------------------------------------+
`default_nettype none

module tb_hazard_control_unit;

    localparam int CNT_W = 32;

    // {pc_wr, if_id_wr, if_id_flush, id_ex_wr, id_ex_flush, ex_me_flush}
    localparam logic [5:0] c_def = 6'b110100;
    localparam logic [5:0] c_rst = 6'b001011;
    localparam logic [5:0] c_bub = 6'b000110;
    localparam logic [5:0] c_br  = 6'b111110;
    localparam logic [5:0] c_mch = 6'b000001;

`ifdef HAZARD_PERF_EN
    localparam bit c_perf = 1'b1;
`else
    localparam bit c_perf = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic [4:0]       id_rs1, id_rs2, ex_rd;
    logic             id_use_rs1, id_use_rs2, ex_ruwr, ex_dmrd;
    logic             ex_br_taken, ex_mc_start, mc_done;
    logic             pc_wr, if_id_wr, if_id_flush, id_ex_wr, id_ex_flush, ex_me_flush;
    logic             mc_timeout;
    logic [1:0]       state_o;
    logic [CNT_W-1:0] stall_cnt, flush_cnt, mc_cnt;

    typedef struct {
        int         idx;
        logic [8:0] exp;
    } sb_item_t;

    sb_item_t sb_q[$];
    int       tests_run = 0;
    int       fail_cnt  = 0;
    int       step_idx  = 0;

    always #5 clk = ~clk;

    hazard_control_unit #(
        .MC_TIMEOUT (4),
        .CNT_W      (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_use_rs1  (id_use_rs1),
        .id_use_rs2  (id_use_rs2),
        .ex_rd       (ex_rd),
        .ex_ruwr     (ex_ruwr),
        .ex_dmrd     (ex_dmrd),
        .ex_br_taken (ex_br_taken),
        .ex_mc_start (ex_mc_start),
        .mc_done     (mc_done),
        .pc_wr       (pc_wr),
        .if_id_wr    (if_id_wr),
        .if_id_flush (if_id_flush),
        .id_ex_wr    (id_ex_wr),
        .id_ex_flush (id_ex_flush),
        .ex_me_flush (ex_me_flush),
        .mc_timeout  (mc_timeout),
        .state_o     (state_o),
        .stall_cnt   (stall_cnt),
        .flush_cnt   (flush_cnt),
        .mc_cnt      (mc_cnt)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            fail_cnt++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Outputs are sampled mid-cycle, on the falling edge
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            sb_item_t it;
            it = sb_q.pop_front();
            check($sformatf("step%0d_outs", it.idx),
                  64'({pc_wr, if_id_wr, if_id_flush, id_ex_wr, id_ex_flush,
                       ex_me_flush, mc_timeout, state_o}),
                  64'(it.exp));
        end
    end

    // Drive one cycle of inputs just after a rising edge, push its expectation
    task automatic step(input logic r, input logic dmrd, input logic ruwr, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic u1, input logic [4:0] rs2, input logic u2,
                        input logic br, input logic mcs, input logic done,
                        input logic [5:0] outs, input logic tmo, input logic [1:0] st);
        sb_item_t it;
        rst = r; ex_dmrd = dmrd; ex_ruwr = ruwr; ex_rd = rd;
        id_rs1 = rs1; id_use_rs1 = u1; id_rs2 = rs2; id_use_rs2 = u2;
        ex_br_taken = br; ex_mc_start = mcs; mc_done = done;
        it.idx = step_idx;
        it.exp = {outs, tmo, st};
        sb_q.push_back(it);
        step_idx++;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic r, input logic [5:0] outs, input logic tmo, input logic [1:0] st);
        step(r, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 0, outs, tmo, st);
    endtask

    initial begin
        rst = 1'b1; ex_dmrd = 0; ex_ruwr = 0; ex_rd = 0; id_rs1 = 0; id_rs2 = 0;
        id_use_rs1 = 0; id_use_rs2 = 0; ex_br_taken = 0; ex_mc_start = 0; mc_done = 0;
        @(posedge clk);
        #1;

        idle(1, c_rst, 0, 2'd0);
        check("rst_stall_cnt", 64'(stall_cnt), 64'd0);
        idle(0, c_def, 0, 2'd0);

        // Load-use on rs1: one bubble, then LU_STALL, then RUN
        step(0, 1, 1, 5'd5, 5'd5, 1, 5'd0, 0, 0, 0, 0, c_bub, 0, 2'd0);
        step(0, 1, 1, 5'd5, 5'd5, 1, 5'd0, 0, 0, 0, 0, c_def, 0, 2'd1);
        check("lu_stall_cnt", 64'(stall_cnt), c_perf ? 64'd1 : 64'd0);
        idle(0, c_def, 0, 2'd0);

        // Non-stalling near misses: x0 destination, unused rs2
        step(0, 1, 1, 5'd0, 5'd0, 1, 5'd0, 1, 0, 0, 0, c_def, 0, 2'd0);
        step(0, 1, 1, 5'd7, 5'd3, 1, 5'd7, 0, 0, 0, 0, c_def, 0, 2'd0);
        step(0, 0, 1, 5'd7, 5'd7, 1, 5'd7, 1, 0, 0, 0, c_def, 0, 2'd0);

        // Taken branch overrides a concurrent load-use
        step(0, 1, 1, 5'd9, 5'd9, 1, 5'd0, 0, 1, 0, 0, c_br, 0, 2'd0);
        check("br_flush_cnt", 64'(flush_cnt), c_perf ? 64'd1 : 64'd0);
        check("br_stall_cnt", 64'(stall_cnt), c_perf ? 64'd1 : 64'd0);
        idle(0, c_def, 0, 2'd0);

        // Multi-cycle op: start at N, done at N+4; branch ignored while waiting
        step(0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 1, 0, c_mch, 0, 2'd0);
        for (int i = 0; i < 3; i++)
            step(0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 1, 1, 0, c_mch, 0, 2'd2);
        step(0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 1, 1, c_def, 0, 2'd2);
        check("mc_cnt", 64'(mc_cnt), c_perf ? 64'd4 : 64'd0);
        idle(0, c_def, 0, 2'd0);

        // mc_done outside MC_WAIT has no effect
        step(0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 1, c_def, 0, 2'd0);

        // Timeout: forced release after four wait cycles, sticky flag
        step(0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 1, 0, c_mch, 0, 2'd0);
        for (int i = 0; i < 3; i++)
            idle(0, c_mch, 0, 2'd2);
        idle(0, c_def, 0, 2'd2);
        idle(0, c_def, 1, 2'd0);
        step(0, 1, 1, 5'd4, 5'd0, 0, 5'd4, 1, 0, 0, 0, c_bub, 1, 2'd0);
        idle(0, c_def, 1, 2'd1);

        // Reset in the middle of a wait aborts it and clears everything
        step(0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 1, 0, c_mch, 1, 2'd0);
        idle(0, c_mch, 1, 2'd2);
        idle(1, c_rst, 1, 2'd2);
        idle(1, c_rst, 0, 2'd0);
        check("rst_mc_cnt", 64'(mc_cnt), 64'd0);
        check("rst_flush_cnt", 64'(flush_cnt), 64'd0);
        check("rst_stall_cnt2", 64'(stall_cnt), 64'd0);
        idle(0, c_def, 0, 2'd0);
        idle(0, c_def, 0, 2'd0);

        @(negedge clk);
        #1;
        if (sb_q.size() != 0)
            check("sb_drained", 64'(sb_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/hazard_control_unit.md
Name: hazard_control_unit

Overview:
- Pipeline sequencer for the 5-stage segmented core (IF/ID/EX/ME/WB).
- Decides per cycle whether PC and pipeline registers advance, hold or flush.
- Covers three cases: load-use stalls, taken-branch squash in EX, and multi-cycle EX ops (divider) with a start/done handshake and timeout.
- Complements operand forwarding: it handles the hazards forwarding cannot resolve.

Parameters:
- MC_TIMEOUT, 64, max cycles in MC_WAIT before forced release; valid range 2..255.
- CNT_W, 32, width of the performance counters.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous active-high reset
- id_rs1  in  5  ID-stage source reg 1
- id_rs2  in  5  ID-stage source reg 2
- id_use_rs1  in  1  ID instruction reads rs1
- id_use_rs2  in  1  ID instruction reads rs2
- ex_rd  in  5  EX-stage dest reg
- ex_ruwr  in  1  EX instruction writes the register file
- ex_dmrd  in  1  EX instruction is a load
- ex_br_taken  in  1  branch/jump resolved taken in EX
- ex_mc_start  in  1  EX holds a multi-cycle op
- mc_done  in  1  multi-cycle unit result valid (1-cycle pulse)
- pc_wr  out  1  PC write enable
- if_id_wr  out  1  IF/ID write enable
- if_id_flush  out  1  IF/ID load NOP
- id_ex_wr  out  1  ID/EX write enable
- id_ex_flush  out  1  ID/EX load NOP
- ex_me_flush  out  1  EX/ME load NOP
- mc_timeout  out  1  sticky error flag
- state_o  out  2  current FSM state
- stall_cnt  out  CNT_W  load-use stall cycles
- flush_cnt  out  CNT_W  branch flush events
- mc_cnt  out  CNT_W  cycles spent in MC_WAIT

Behaviour:
- Registers: state, mc timer (8 b), mc_timeout. Enables/flushes are combinational from state plus current inputs (same-cycle effect).
- Reset (rst=1 at a clk edge):
  - state=RUN, timer=0, mc_timeout=0, counters=0.
  - While rst=1: pc_wr=0, if_id_wr=0, id_ex_wr=0, if_id_flush=1, id_ex_flush=1, ex_me_flush=1.
  - Reset mid-MC_WAIT aborts the wait, with no timeout flag.
- Default (no hazard): all wr=1, all flush=0.
- lu_hit = ex_dmrd & ex_ruwr & ex_rd!=0 & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
- Priority in RUN: ex_mc_start > ex_br_taken > lu_hit.
- RUN, ex_mc_start=1:
  - Outputs: pc_wr=0, if_id_wr=0, id_ex_wr=0, ex_me_flush=1.
  - Next state MC_WAIT, timer<=1.
- RUN, ex_br_taken=1: if_id_flush=1, id_ex_flush=1, wr=1 (redirected PC loads). Stay in RUN. Any lu_hit this cycle is ignored because the ID instruction is squashed.
- RUN, lu_hit=1: pc_wr=0, if_id_wr=0, id_ex_flush=1 (bubble). Next state LU_STALL.
- LU_STALL: default outputs, lu_hit not evaluated. Next state RUN. Exactly one bubble per load-use.
- MC_WAIT:
  - ex_mc_start and ex_br_taken are ignored.
  - mc_done=0 and timer<MC_TIMEOUT: hold outputs as on entry; timer++.
  - mc_done=1: default outputs (result advances to ME). Next state RUN, timer<=0.
  - mc_done=0 and timer==MC_TIMEOUT: default outputs, mc_timeout<=1 (sticky until rst), next state RUN.
  - mc_done outside MC_WAIT is ignored.
- state_o encoding: RUN=0, LU_STALL=1, MC_WAIT=2. Value 3 is illegal and recovers to RUN next cycle with default outputs.
- ex_rd==0 never causes a stall.

Optional Feature:
- Macro: HAZARD_PERF_EN.
- Defined:
  - stall_cnt increments each lu_hit bubble cycle.
  - flush_cnt increments each honoured ex_br_taken.
  - mc_cnt increments each cycle in MC_WAIT.
  - All counters saturate at all-ones and clear on rst.
- Undefined: the three counter outputs are tied to 0 and no counter flops are built. The port list is unchanged.

Decomposition:
- Shared package seg_pkg:
  - typedef enum logic[1:0] hz_state_t {RUN, LU_STALL, MC_WAIT}
  - constant REG_ZERO = 5'd0
  - NOP-related constants already used by the pipeline registers.
- One sub-module: hazard_perf_counters (three saturating CNT_W counters with increment strobes), instantiated only under HAZARD_PERF_EN.

Test Plan:
- Load-use: ex_dmrd=1, ex_ruwr=1, ex_rd=5, id_rs1=5, id_use_rs1=1 → one cycle of pc_wr=0, if_id_wr=0, id_ex_flush=1, then state_o=1, then 0. stall_cnt=1 with HAZARD_PERF_EN.
- ex_rd=0 with an otherwise matching load, or id_use_rs2=0 with rs2 matching → no stall.
- ex_br_taken=1 together with lu_hit → if_id_flush=1, id_ex_flush=1, pc_wr=1, no stall, flush_cnt=1.
- ex_mc_start at cycle N, mc_done at N+4 → holds and ex_me_flush=1 for cycles N..N+3; release at N+4; state_o back to 0 at N+5; mc_cnt=4.
- MC_TIMEOUT=4, mc_done never asserted → forced release after 4 MC_WAIT cycles, mc_timeout=1 and stays set until rst.
- rst asserted during MC_WAIT → next cycle state_o=0, mc_timeout=0, counters=0; flush outputs =1 while rst is held.
